// File: rtl/softusb_rxseq_defs.sv
`default_nettype none
// ============================================================================
//  Module      : softusb_rxseq_defs
//  Description : Shared PID-class and completion-status codes for the USB
//                receive sequencer and its firmware-facing register blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package softusb_rxseq_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        PID   = 3'd2,
        BODY  = 3'd3,
        DRAIN = 3'd4
    } rxseq_state_t;

    // Completion status codes; TIMEOUT and TOGGLE share one code by design
    localparam logic [2:0] c_st_hs_ok   = 3'd0;
    localparam logic [2:0] c_st_data_ok = 3'd1;
    localparam logic [2:0] c_st_timeout = 3'd2;
    localparam logic [2:0] c_st_toggle  = 3'd2;
    localparam logic [2:0] c_st_stuff   = 3'd3;
    localparam logic [2:0] c_st_piderr  = 3'd4;
    localparam logic [2:0] c_st_badpid  = 3'd5;
    localparam logic [2:0] c_st_crc     = 3'd6;
    localparam logic [2:0] c_st_babble  = 3'd7;

    localparam logic [1:0] c_pid_hs_class   = 2'b10;
    localparam logic [2:0] c_pid_data_class = 3'b011;

    function automatic logic pid_is_handshake(input logic [3:0] pid);
        return pid[1:0] == c_pid_hs_class;
    endfunction

    function automatic logic pid_is_data(input logic [3:0] pid);
        return pid[2:0] == c_pid_data_class;
    endfunction

endpackage
`default_nettype wire

// File: rtl/softusb_rxseq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : softusb_rxseq_timer
//  Description : 10-bit response timer; limit captured on load, expire is
//                flagged during the last counted cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module softusb_rxseq_timer (
    input  logic       usb_clk,
    input  logic       usb_rst,
    input  logic       i_load,
    input  logic [9:0] i_limit,
    input  logic       i_en,
    output logic       o_expire
);

    logic [9:0] r_count;
    logic [9:0] r_limit;

    always_ff @(posedge usb_clk) begin
        if (usb_rst) begin
            r_count <= 10'd0;
            r_limit <= 10'd0;
        end else if (i_load) begin
            r_count <= 10'd0;
            r_limit <= i_limit;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + 10'd1;
        end
    end

    assign o_expire = i_en && (r_count == (r_limit - 10'd1));

endmodule
`default_nettype wire

// File: rtl/softusb_rxseq.sv
`default_nettype none
// ============================================================================
//  Module      : softusb_rxseq
//  Description : USB receive sequencer: waits for a response packet, stores
//                its body into the packet buffer and reports a status code.
//  Revision    : 1.0  initial release
// ============================================================================
module softusb_rxseq #(
    parameter int MAXLEN = 64,
    parameter int TO_FS  = 72,
    parameter int TO_LS  = 576
) (
    input  logic       usb_clk,
    input  logic       usb_rst,
    input  logic       arm,
    input  logic       expect_data,
    input  logic       exp_toggle,
    input  logic       low_speed,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_active,
    input  logic       rx_sync,
    input  logic       rx_eop,
    input  logic       rx_error,
    input  logic       rx_pid_error,
    input  logic       rx_crc_error,
    output logic       rxreset,
    output logic       buf_we,
    output logic [6:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic [7:0] rx_len,
    output logic [3:0] pid_out
);
    import softusb_rxseq_defs::*;

    // Body capacity counts the two CRC bytes on top of the payload
    localparam logic [7:0] c_cap   = 8'(MAXLEN + 2);
    localparam logic [9:0] c_to_fs = 10'(TO_FS);
    localparam logic [9:0] c_to_ls = 10'(TO_LS);

    rxseq_state_t r_state;
    rxseq_state_t w_state_next;

    logic       r_expect_data;
    logic       r_exp_toggle;
    logic [7:0] r_count;
    logic       r_overflow;
    logic       r_rx_active_q;
    logic       r_buf_we;
    logic [6:0] r_buf_addr;
    logic [7:0] r_buf_wdata;
    logic       r_done;
    logic [2:0] r_status;
    logic [7:0] r_rx_len;
    logic [3:0] r_pid;

    logic       w_expire;
    logic       w_accept_arm;
    logic       w_pid_latch;
    logic       w_write;
    logic       w_overrun;
    logic       w_finish;
    logic [2:0] w_status;
    logic [7:0] w_len;
    logic       w_class_bad;
    logic [2:0] w_eop_status;

    softusb_rxseq_timer u_timer (
        .usb_clk  (usb_clk),
        .usb_rst  (usb_rst),
        .i_load   (w_accept_arm),
        .i_limit  (low_speed ? c_to_ls : c_to_fs),
        .i_en     (r_state == WAIT),
        .o_expire (w_expire)
    );

    // Once the class check passes, "data packet" is simply expect_data
    always_comb begin
        w_class_bad = r_expect_data ? !pid_is_data(r_pid) : !pid_is_handshake(r_pid);
        if (rx_error)
            w_eop_status = c_st_stuff;
        else if (rx_pid_error || (r_state == PID))
            w_eop_status = c_st_piderr;
        else if (w_class_bad)
            w_eop_status = c_st_badpid;
        else if (r_overflow || (!r_expect_data && (r_count != 8'd0)))
            w_eop_status = c_st_babble;
        else if (rx_crc_error || (r_expect_data && (r_count < 8'd2)))
            w_eop_status = c_st_crc;
        else if (r_expect_data && (r_pid[3] != r_exp_toggle))
            w_eop_status = c_st_toggle;
        else if (r_expect_data)
            w_eop_status = c_st_data_ok;
        else
            w_eop_status = c_st_hs_ok;
    end

    always_ff @(posedge usb_clk) begin
        if (usb_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept_arm = 1'b0;
        w_pid_latch  = 1'b0;
        w_write      = 1'b0;
        w_overrun    = 1'b0;
        w_finish     = 1'b0;
        w_status     = c_st_hs_ok;
        w_len        = 8'd0;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_accept_arm = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (rx_sync) begin
                    w_state_next = PID;
                end else if (w_expire) begin
                    w_finish     = 1'b1;
                    w_status     = c_st_timeout;
                    w_state_next = IDLE;
                end
            end
            PID, BODY: begin
                if (rx_eop) begin
                    w_finish     = 1'b1;
                    w_status     = w_eop_status;
                    if ((w_eop_status == c_st_data_ok) || (w_eop_status == c_st_toggle))
                        w_len = r_count - 8'd2;
                    w_state_next = IDLE;
                end else if (r_rx_active_q && !rx_active) begin
                    w_state_next = DRAIN;
                end else if (rx_valid) begin
                    if (r_state == PID) begin
                        w_pid_latch  = 1'b1;
                        w_state_next = BODY;
                    end else if (r_count == c_cap) begin
                        w_overrun = 1'b1;
                    end else begin
                        w_write = 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_finish     = 1'b1;
                w_status     = c_st_stuff;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (usb_rst) begin
            r_expect_data <= 1'b0;
            r_exp_toggle  <= 1'b0;
            r_count       <= 8'd0;
            r_overflow    <= 1'b0;
            r_rx_active_q <= 1'b0;
            r_buf_we      <= 1'b0;
            r_buf_addr    <= 7'd0;
            r_buf_wdata   <= 8'd0;
            r_done        <= 1'b0;
            r_status      <= 3'd0;
            r_rx_len      <= 8'd0;
            r_pid         <= 4'd0;
        end else begin
            r_buf_we      <= w_write;
            r_done        <= w_finish;
            r_rx_active_q <= rx_active;
            if (w_accept_arm) begin
                r_expect_data <= expect_data;
                r_exp_toggle  <= exp_toggle;
                r_count       <= 8'd0;
                r_overflow    <= 1'b0;
                r_pid         <= 4'd0;
            end
            if (w_pid_latch)
                r_pid <= rx_data[3:0];
            if (w_write) begin
                r_buf_addr  <= r_count[6:0];
                r_buf_wdata <= rx_data;
                r_count     <= r_count + 8'd1;
            end
            if (w_overrun)
                r_overflow <= 1'b1;
            if (w_finish) begin
                r_status <= w_status;
                r_rx_len <= w_len;
            end
        end
    end

    assign rxreset   = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign buf_we    = r_buf_we;
    assign buf_addr  = r_buf_addr;
    assign buf_wdata = r_buf_wdata;
    assign done      = r_done;
    assign status    = r_status;
    assign rx_len    = r_rx_len;
    assign pid_out   = r_pid;

endmodule
`default_nettype wire

// File: tb/tb_softusb_rxseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softusb_rxseq
//  Description : Self-checking bench for softusb_rxseq: packet table plus
//                timeout, drain and reset sequences, scoreboard-checked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_softusb_rxseq;

    localparam int F_WAIT_EOP = 1;
    localparam int F_EOP_ARM  = 2;
    localparam int F_ARM_BUSY = 4;
    localparam int F_NO_PID   = 8;

    logic       usb_clk = 1'b0;
    logic       usb_rst = 1'b1;
    logic       arm = 1'b0, expect_data = 1'b0, exp_toggle = 1'b0, low_speed = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0, rx_active = 1'b0, rx_sync = 1'b0, rx_eop = 1'b0;
    logic       rx_error = 1'b0, rx_pid_error = 1'b0, rx_crc_error = 1'b0;
    logic       rxreset, buf_we, busy, done;
    logic [6:0] buf_addr;
    logic [7:0] buf_wdata, rx_len;
    logic [2:0] status;
    logic [3:0] pid_out;

    softusb_rxseq dut (
        .usb_clk(usb_clk), .usb_rst(usb_rst), .arm(arm), .expect_data(expect_data),
        .exp_toggle(exp_toggle), .low_speed(low_speed), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_active(rx_active), .rx_sync(rx_sync), .rx_eop(rx_eop),
        .rx_error(rx_error), .rx_pid_error(rx_pid_error), .rx_crc_error(rx_crc_error),
        .rxreset(rxreset), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .busy(busy), .done(done), .status(status), .rx_len(rx_len), .pid_out(pid_out)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic       ed, tog;
        logic [7:0] pid;
        int         nbody;
        logic       stuff, piderr, crc;
        int         flags;
        logic [2:0] st;
        logic [7:0] len;
        logic [3:0] pido;
    } vec_t;

    typedef struct { logic [2:0] st; logic [7:0] len; logic [3:0] pid; } res_t;
    typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;

    vec_t vecs[$];
    res_t rq[$];
    wr_t  wq[$];
    res_t m_r;
    wr_t  m_w;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not as required at %0t", nm, $time);
    endfunction

    function automatic vec_t mkv(input logic ed, input logic tog, input logic [7:0] pid,
                                 input int nbody, input logic stuff, input logic piderr,
                                 input logic crc, input int flags, input logic [2:0] st,
                                 input logic [7:0] len, input logic [3:0] pido);
        vec_t v;
        v.ed = ed; v.tog = tog; v.pid = pid; v.nbody = nbody;
        v.stuff = stuff; v.piderr = piderr; v.crc = crc; v.flags = flags;
        v.st = st; v.len = len; v.pido = pido;
        return v;
    endfunction

    function automatic logic [7:0] body_byte(input int i);
        return 8'((i * 13) + 5);
    endfunction

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic push_res(input logic [2:0] st, input logic [7:0] len, input logic [3:0] pid);
        res_t r;
        r.st = st; r.len = len; r.pid = pid;
        rq.push_back(r);
    endtask

    // Scoreboard side: writes and completions are popped as the DUT emits them
    always @(negedge usb_clk) begin
        if (buf_we === 1'b1) begin
            if (wq.size() == 0) fail("unexpected_write");
            else begin
                m_w = wq.pop_front();
                check("buf_addr", 32'(buf_addr), 32'(m_w.a));
                check("buf_wdata", 32'(buf_wdata), 32'(m_w.d));
            end
        end
        if (done === 1'b1) begin
            if (rq.size() == 0) fail("unexpected_done");
            else begin
                m_r = rq.pop_front();
                check("status", 32'(status), 32'(m_r.st));
                check("rx_len", 32'(rx_len), 32'(m_r.len));
                check("pid_out", 32'(pid_out), 32'(m_r.pid));
                check("writes_missing", 32'(wq.size()), 32'd0);
            end
        end
    end

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while ((rq.size() != 0) && (k < bound)) begin
            tick();
            k++;
        end
        if (rq.size() != 0) begin
            fail("done_timeout");
            rq.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        wr_t w;
        tick();
        arm = 1'b1; expect_data = v.ed; exp_toggle = v.tog; low_speed = 1'b0;
        if ((v.flags & F_EOP_ARM) != 0) rx_eop = 1'b1;
        push_res(v.st, v.len, v.pido);
        tick();
        arm = 1'b0; rx_eop = 1'b0;
        if ((v.flags & F_WAIT_EOP) != 0) begin
            rx_eop = 1'b1;
            tick();
            rx_eop = 1'b0;
        end
        tick();
        rx_sync = 1'b1; rx_active = 1'b1;
        tick();
        rx_sync = 1'b0;
        if ((v.flags & F_NO_PID) == 0) begin
            rx_data = v.pid; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < v.nbody; i++) begin
            rx_data = body_byte(i); rx_valid = 1'b1;
            if (i < 66) begin
                w.a = 7'(i); w.d = body_byte(i);
                wq.push_back(w);
            end
            // An arm landing mid-packet must be ignored
            if (((v.flags & F_ARM_BUSY) != 0) && (i == 0)) begin
                arm = 1'b1; expect_data = ~v.ed; exp_toggle = ~v.tog;
            end
            tick();
            rx_valid = 1'b0; arm = 1'b0;
            tick();
        end
        rx_eop = 1'b1; rx_error = v.stuff; rx_pid_error = v.piderr; rx_crc_error = v.crc;
        tick();
        rx_eop = 1'b0; rx_error = 1'b0; rx_pid_error = 1'b0; rx_crc_error = 1'b0;
        rx_active = 1'b0;
        wait_done(10);
        repeat (3) tick();
        check("status_hold", 32'(status), 32'(v.st));
        check("idle_busy", 32'(busy), 32'd0);
        wq.delete();
    endtask

    task automatic run_timeout(input logic ls, input int limit, input logic flip);
        int n;
        tick();
        arm = 1'b1; expect_data = 1'b0; low_speed = ls;
        push_res(3'd2, 8'd0, 4'd0);
        tick();
        arm = 1'b0;
        check("wait_rxreset", 32'(rxreset), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        if (flip) low_speed = ~ls;
        n = 0;
        while ((done !== 1'b1) && (n < limit + 20)) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(limit));
        tick();
        low_speed = 1'b0;
        wait_done(2);
    endtask

    initial begin
        vecs.push_back(mkv(0, 0, 8'hD2, 0,  0, 0, 0, F_EOP_ARM | F_WAIT_EOP, 3'd0, 8'd0,  4'h2));
        vecs.push_back(mkv(1, 1, 8'h4B, 6,  0, 0, 0, F_ARM_BUSY,             3'd1, 8'd4,  4'hB));
        vecs.push_back(mkv(1, 0, 8'h4B, 6,  0, 0, 0, 0,                      3'd2, 8'd4,  4'hB));
        vecs.push_back(mkv(1, 0, 8'hC3, 70, 0, 0, 0, 0,                      3'd7, 8'd0,  4'h3));
        vecs.push_back(mkv(1, 0, 8'hC3, 66, 0, 0, 0, 0,                      3'd1, 8'd64, 4'h3));
        vecs.push_back(mkv(1, 0, 8'hC3, 67, 0, 0, 0, 0,                      3'd7, 8'd0,  4'h3));
        vecs.push_back(mkv(1, 0, 8'hC3, 3,  1, 0, 0, 0,                      3'd3, 8'd0,  4'h3));
        vecs.push_back(mkv(1, 1, 8'h4B, 2,  0, 1, 0, 0,                      3'd4, 8'd0,  4'hB));
        vecs.push_back(mkv(1, 0, 8'hD2, 0,  0, 0, 0, 0,                      3'd5, 8'd0,  4'h2));
        vecs.push_back(mkv(0, 0, 8'hC3, 2,  0, 0, 0, 0,                      3'd5, 8'd0,  4'h3));
        vecs.push_back(mkv(0, 0, 8'h5A, 1,  0, 0, 0, 0,                      3'd7, 8'd0,  4'hA));
        vecs.push_back(mkv(1, 0, 8'hC3, 4,  0, 0, 1, 0,                      3'd6, 8'd0,  4'h3));
        vecs.push_back(mkv(1, 0, 8'hC3, 2,  0, 0, 0, 0,                      3'd1, 8'd0,  4'h3));
        vecs.push_back(mkv(1, 1, 8'h4B, 1,  0, 0, 0, 0,                      3'd6, 8'd0,  4'hB));
        vecs.push_back(mkv(0, 0, 8'h1E, 0,  0, 0, 0, 0,                      3'd0, 8'd0,  4'hE));
        vecs.push_back(mkv(0, 0, 8'h00, 0,  0, 0, 0, F_NO_PID,               3'd4, 8'd0,  4'h0));

        repeat (3) tick();
        check("rst_rxreset", 32'(rxreset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_buf_we", 32'(buf_we), 32'd0);
        check("rst_buf_addr", 32'(buf_addr), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_rx_len", 32'(rx_len), 32'd0);
        check("rst_pid_out", 32'(pid_out), 32'd0);
        usb_rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        run_timeout(1'b0, 72, 1'b1);
        run_timeout(1'b1, 576, 1'b0);
        run_timeout(1'b1, 576, 1'b1);

        // rx_active drops without EOP: STUFF reported two edges later
        begin
            wr_t w;
            int n;
            tick();
            arm = 1'b1; expect_data = 1'b1; exp_toggle = 1'b0;
            push_res(3'd3, 8'd0, 4'h3);
            tick();
            arm = 1'b0;
            rx_sync = 1'b1; rx_active = 1'b1;
            tick();
            rx_sync = 1'b0; rx_data = 8'hC3; rx_valid = 1'b1;
            tick();
            for (int i = 0; i < 2; i++) begin
                rx_data = body_byte(i); rx_valid = 1'b1;
                w.a = 7'(i); w.d = body_byte(i);
                wq.push_back(w);
                tick();
            end
            rx_valid = 1'b0; rx_active = 1'b0;
            n = 0;
            while ((done !== 1'b1) && (n < 10)) begin
                tick();
                n++;
            end
            check("drain_latency", 32'(n), 32'd2);
            tick();
            wait_done(2);
        end

        // Reset in the middle of a body aborts without a done pulse
        begin
            wr_t w;
            tick();
            arm = 1'b1; expect_data = 1'b1; exp_toggle = 1'b1;
            tick();
            arm = 1'b0;
            rx_sync = 1'b1; rx_active = 1'b1;
            tick();
            rx_sync = 1'b0; rx_data = 8'h4B; rx_valid = 1'b1;
            tick();
            for (int i = 0; i < 2; i++) begin
                rx_data = body_byte(i); rx_valid = 1'b1;
                w.a = 7'(i); w.d = body_byte(i);
                wq.push_back(w);
                tick();
            end
            rx_valid = 1'b0;
            usb_rst = 1'b1;
            tick();
            check("abort_rxreset", 32'(rxreset), 32'd1);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            usb_rst = 1'b0; rx_active = 1'b0; rx_eop = 1'b1;
            tick();
            rx_eop = 1'b0;
            repeat (20) tick();
            check("abort_writes_left", 32'(wq.size()), 32'd0);
            check("abort_status", 32'(status), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
